// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings and helpers for the multi-requester master front end.
package ahb_lite_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_e;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // data, privileged, non-bufferable, non-cacheable
    localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ahb_rr_arbiter.sv
// Combinational round-robin arbiter with lock override; the pointer register lives in the caller.
module ahb_rr_arbiter
    import ahb_lite_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IW   = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic            lock_owner_valid,
    input  logic [IW-1:0]   lock_owner,
    input  logic [IW-1:0]   pointer,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx
);

    int unsigned   w_cand;
    logic [IW-1:0] w_cidx;
    logic          w_found;

    always_comb begin
        gnt     = '0;
        idx     = '0;
        w_cand  = 0;
        w_cidx  = '0;
        w_found = 1'b0;
        if (lock_owner_valid) begin
            // A held lock excludes everyone else, even if the owner is momentarily idle.
            if (req[lock_owner]) begin
                gnt[lock_owner] = 1'b1;
                idx             = lock_owner;
            end
        end else begin
            for (int unsigned k = 1; k <= NREQ; k++) begin
                w_cand = (32'(pointer) + k) % NREQ;
                w_cidx = IW'(w_cand);
                if (!w_found && req[w_cidx]) begin
                    w_found     = 1'b1;
                    gnt[w_cidx] = 1'b1;
                    idx         = w_cidx;
                end
            end
        end
    end

endmodule

// File: rtl/ahb_lite_master_arb.sv
// AHB-Lite master front end: round-robin arbitration of single-beat requests onto one
// pipelined address/data bus, with bus locking, error-abort of the queued transfer and per-requester responses.
module ahb_lite_master_arb
    import ahb_lite_pkg::*;
#(
    parameter int unsigned NREQ      = 2,
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 32,
    parameter logic [3:0]  HPROT_VAL = HPROT_DEFAULT
) (
    input  logic               hclk,
    input  logic               hresetn,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    req_write,
    input  logic [NREQ-1:0]    req_lock,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    input  logic [NREQ*3-1:0]  req_size,
    output logic [NREQ-1:0]    req_gnt,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [DW-1:0]      rsp_rdata,
    output logic               rsp_err,
    input  logic               err_clr,
    output logic               hsel,
    output logic [AW-1:0]      haddr,
    output logic               hwrite,
    output logic [2:0]         hsize,
    output logic [2:0]         hburst,
    output logic [3:0]         hprot,
    output logic [1:0]         htrans,
    output logic               hmastlock,
    output logic [DW-1:0]      hwdata,
    output logic               error,
    input  logic               hready,
    input  logic               hresp,
    input  logic [DW-1:0]      hrdata
);

    localparam int unsigned IW = idx_width(NREQ);

    logic          r_a_valid;
    logic          r_a_abort;
    logic [IW-1:0] r_a_owner;
    logic          r_a_write;
    logic          r_a_lock;
    logic [AW-1:0] r_a_addr;
    logic [2:0]    r_a_size;
    logic [DW-1:0] r_a_wdata;

    logic          r_d_valid;
    logic          r_d_abort;
    logic [IW-1:0] r_d_owner;
    logic          r_d_write;
    logic [DW-1:0] r_d_wdata;

    logic [IW-1:0] r_ptr;
    logic          r_last_lock;
    logic [IW-1:0] r_last_owner;

    logic [NREQ-1:0] r_rsp_valid;
    logic [DW-1:0]   r_rsp_rdata;
    logic            r_rsp_err;
    logic            r_error;

    logic            w_err1;
    logic            w_slot_free;
    logic [IW-1:0]   w_lock_own;
    logic            w_lock_valid;
    logic [NREQ-1:0] w_arb_gnt;
    logic [IW-1:0]   w_arb_idx;
    logic            w_grant;
    logic [AW-1:0]   w_sel_addr;
    logic [DW-1:0]   w_sel_wdata;
    logic [2:0]      w_sel_size;
    logic            w_sel_write;
    logic            w_sel_lock;
    logic            w_rsp_fire;
    logic            w_rsp_err_nxt;
    logic [NREQ-1:0] w_rsp_vec;
    htrans_e         w_htrans;

    assign w_err1      = r_d_valid && (hresp == HRESP_ERROR) && !hready;
    assign w_slot_free = (!r_a_valid || hready) && !w_err1;

    assign w_lock_own   = (r_a_valid && r_a_lock) ? r_a_owner : r_last_owner;
    assign w_lock_valid = ((r_a_valid && r_a_lock) || r_last_lock) && req_lock[w_lock_own];

    ahb_rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req              (req),
        .lock_owner_valid (w_lock_valid),
        .lock_owner       (w_lock_own),
        .pointer          (r_ptr),
        .gnt              (w_arb_gnt),
        .idx              (w_arb_idx)
    );

    assign req_gnt = w_slot_free ? w_arb_gnt : '0;
    assign w_grant = w_slot_free && (|w_arb_gnt);

    assign w_sel_addr  = req_addr[w_arb_idx*AW +: AW];
    assign w_sel_wdata = req_wdata[w_arb_idx*DW +: DW];
    assign w_sel_size  = req_size[w_arb_idx*3 +: 3];
    assign w_sel_write = req_write[w_arb_idx];
    assign w_sel_lock  = req_lock[w_arb_idx];

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_a_valid    <= 1'b0;
            r_a_abort    <= 1'b0;
            r_a_owner    <= '0;
            r_a_write    <= 1'b0;
            r_a_lock     <= 1'b0;
            r_a_addr     <= '0;
            r_a_size     <= '0;
            r_a_wdata    <= '0;
            r_d_valid    <= 1'b0;
            r_d_abort    <= 1'b0;
            r_d_owner    <= '0;
            r_d_write    <= 1'b0;
            r_d_wdata    <= '0;
            r_ptr        <= IW'(NREQ - 1);
            r_last_lock  <= 1'b0;
            r_last_owner <= '0;
        end else begin
            if (w_grant) begin
                r_a_valid    <= 1'b1;
                r_a_abort    <= 1'b0;
                r_a_owner    <= w_arb_idx;
                r_a_write    <= w_sel_write;
                r_a_lock     <= w_sel_lock;
                r_a_addr     <= w_sel_addr;
                r_a_size     <= w_sel_size;
                r_a_wdata    <= w_sel_wdata;
                r_ptr        <= w_arb_idx;
                r_last_lock  <= w_sel_lock;
                r_last_owner <= w_arb_idx;
            end else if (hready) begin
                r_a_valid <= 1'b0;
            end else if (w_err1 && r_a_valid) begin
                r_a_abort <= 1'b1;
            end

            if (hready) begin
                r_d_valid <= r_a_valid;
                r_d_abort <= r_a_abort;
                r_d_owner <= r_a_owner;
                r_d_write <= r_a_write;
                r_d_wdata <= r_a_wdata;
            end
        end
    end

    assign w_rsp_fire    = hready && r_d_valid;
    assign w_rsp_err_nxt = (hresp == HRESP_ERROR) || r_d_abort;

    always_comb begin
        w_rsp_vec = '0;
        if (w_rsp_fire) begin
            w_rsp_vec[r_d_owner] = 1'b1;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_rsp_valid <= w_rsp_vec;
            r_rsp_rdata <= (w_rsp_fire && !r_d_write && !r_d_abort) ? hrdata : '0;
            r_rsp_err   <= w_rsp_fire && w_rsp_err_nxt;
            if (w_rsp_fire && w_rsp_err_nxt) begin
                r_error <= 1'b1;
            end else if (err_clr) begin
                r_error <= 1'b0;
            end
        end
    end

    // htrans drops to IDLE combinationally in the first error cycle, before abort is registered.
    assign w_htrans  = (r_a_valid && !r_a_abort && !w_err1) ? NONSEQ : IDLE;
    assign htrans    = w_htrans;
    assign hmastlock = r_a_valid && r_a_lock;
    assign hsel      = (r_a_valid && !r_a_abort) || (r_d_valid && !r_d_abort);
    assign haddr     = r_a_addr;
    assign hwrite    = r_a_write;
    assign hsize     = r_a_size;
    assign hwdata    = r_d_wdata;
    assign hburst    = HBURST_SINGLE;
    assign hprot     = HPROT_VAL;

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign error     = r_error;

endmodule

// File: tb/tb_ahb_lite_master_arb.sv
// Directed bench for ahb_lite_master_arb: stimulus pushes expected responses into a scoreboard
// that a separate monitor drains; bus-side timing is checked inline.
module tb_ahb_lite_master_arb;

    logic        hclk;
    logic        hresetn;
    logic [1:0]  req;
    logic [1:0]  req_write;
    logic [1:0]  req_lock;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [5:0]  req_size;
    logic [1:0]  req_gnt;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        err_clr;
    logic        hsel;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [1:0]  htrans;
    logic        hmastlock;
    logic [31:0] hwdata;
    logic        error;
    logic        hready;
    logic        hresp;
    logic [31:0] hrdata;

    logic [31:0] dph_addr;
    logic        rd_ovr_en;
    logic [31:0] rd_ovr;

    typedef struct {
        int          owner;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int n_checks;
    int n_errors;

    logic [31:0] a0, a1, cur, prev;
    int          w;

    ahb_lite_master_arb #(
        .NREQ      (2),
        .AW        (32),
        .DW        (32),
        .HPROT_VAL (4'b0011)
    ) dut (
        .hclk      (hclk),
        .hresetn   (hresetn),
        .req       (req),
        .req_write (req_write),
        .req_lock  (req_lock),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_size  (req_size),
        .req_gnt   (req_gnt),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .err_clr   (err_clr),
        .hsel      (hsel),
        .haddr     (haddr),
        .hwrite    (hwrite),
        .hsize     (hsize),
        .hburst    (hburst),
        .hprot     (hprot),
        .htrans    (htrans),
        .hmastlock (hmastlock),
        .hwdata    (hwdata),
        .error     (error),
        .hready    (hready),
        .hresp     (hresp),
        .hrdata    (hrdata)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    // Slave model: read data is derived from the address of the transfer in its data phase.
    always @(posedge hclk) begin
        if (hready) dph_addr <= haddr;
    end
    assign hrdata = rd_ovr_en ? rd_ovr : (dph_addr ^ 32'hC0DE_0000);

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic push(input int o, input logic [31:0] d, input logic e);
        exp_t t;
        t.owner = o;
        t.rdata = d;
        t.err   = e;
        sb.push_back(t);
    endtask

    task automatic cyc();
        @(posedge hclk);
        #1;
    endtask

    task automatic smp();
        @(negedge hclk);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic set_req(input int i, input logic v, input logic wr, input logic lk,
                           input logic [31:0] a, input logic [31:0] d);
        req[i]               = v;
        req_write[i]         = wr;
        req_lock[i]          = lk;
        req_addr[i*32 +: 32]  = a;
        req_wdata[i*32 +: 32] = d;
        req_size[i*3 +: 3]    = 3'b010;
    endtask

    always @(negedge hclk) begin
        if (rsp_valid != 2'b00) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL rsp_unexpected: got rsp_valid=%b, expected no response at %0t", rsp_valid, $time);
            end else begin
                mon_e = sb.pop_front();
                chk("rsp_owner", 64'(rsp_valid), 64'(1) << mon_e.owner);
                chk("rsp_rdata", 64'(rsp_rdata), 64'(mon_e.rdata));
                chk("rsp_err", 64'(rsp_err), 64'(mon_e.err));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        hresetn   = 1'b0;
        req       = '0;
        req_write = '0;
        req_lock  = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_size  = '0;
        err_clr   = 1'b0;
        hready    = 1'b1;
        hresp     = 1'b0;
        rd_ovr_en = 1'b0;
        rd_ovr    = '0;
        dph_addr  = '0;

        repeat (2) @(posedge hclk);
        smp();
        chk("rst_htrans", htrans, 0);
        chk("rst_hsel", hsel, 0);
        chk("rst_hmastlock", hmastlock, 0);
        chk("rst_haddr", haddr, 0);
        chk("rst_hwdata", hwdata, 0);
        chk("rst_hwrite_hsize", {hwrite, hsize}, 0);
        chk("rst_rsp", {rsp_valid, rsp_rdata, rsp_err}, 0);
        chk("rst_error", error, 0);
        chk("hburst", hburst, 0);
        chk("hprot", hprot, 4'b0011);
        chk("rst_gnt", req_gnt, 0);
        cyc();
        hresetn = 1'b1;

        // Contention: both requesters read continuously.
        cyc();
        a0 = 32'h100;
        a1 = 32'h200;
        set_req(0, 1, 0, 0, a0, 0);
        set_req(1, 1, 0, 0, a1, 0);
        prev = '0;
        for (int k = 0; k < 4; k++) begin
            smp();
            w = k % 2;
            chk("cont_gnt", req_gnt, 64'(1) << w);
            if (k > 0) begin
                chk("cont_htrans", htrans, 2);
                chk("cont_haddr", haddr, prev);
            end
            cur = (w == 0) ? a0 : a1;
            push(w, cur ^ 32'hC0DE_0000, 1'b0);
            prev = cur;
            cyc();
            if (w == 0) begin
                a0 = a0 + 4;
                set_req(0, 1, 0, 0, a0, 0);
            end else begin
                a1 = a1 + 4;
                set_req(1, 1, 0, 0, a1, 0);
            end
            if (k == 3) req = '0;
        end
        smp();
        chk("cont_htrans_last", htrans, 2);
        chk("cont_haddr_last", haddr, 32'h204);

        // Zero-wait write.
        idle(4);
        set_req(0, 1, 1, 0, 32'h10, 32'hA5A5_A5A5);
        smp();
        chk("zw_gnt", req_gnt, 2'b01);
        push(0, 32'h0, 1'b0);
        cyc();
        req = '0;
        smp();
        chk("zw_htrans", htrans, 2);
        chk("zw_haddr", haddr, 32'h10);
        chk("zw_hwrite_hsize", {hwrite, hsize}, 4'b1010);
        cyc();
        smp();
        chk("zw_hwdata", hwdata, 32'hA5A5_A5A5);
        chk("zw_htrans_idle", htrans, 0);
        cyc();
        smp();
        chk("zw_rsp_valid", rsp_valid, 2'b01);

        // Wait states in the data phase of a read.
        idle(4);
        set_req(1, 1, 0, 0, 32'h300, 0);
        smp();
        chk("ws_gnt1", req_gnt, 2'b10);
        push(1, 32'hDEAD_BEEF, 1'b0);
        cyc();
        req[1] = 1'b0;
        set_req(0, 1, 0, 0, 32'h400, 0);
        smp();
        chk("ws_gnt0", req_gnt, 2'b01);
        chk("ws_haddr0", haddr, 32'h300);
        push(0, 32'hC0DE_0400, 1'b0);
        cyc();
        req[0] = 1'b0;
        hready = 1'b0;
        smp();
        chk("ws_haddr_hold0", haddr, 32'h400);
        cyc();
        smp();
        chk("ws_haddr_hold1", haddr, 32'h400);
        chk("ws_no_rsp0", rsp_valid, 0);
        cyc();
        hready    = 1'b1;
        rd_ovr_en = 1'b1;
        rd_ovr    = 32'hDEAD_BEEF;
        smp();
        chk("ws_no_rsp1", rsp_valid, 0);
        cyc();
        rd_ovr_en = 1'b0;
        smp();
        chk("ws_rsp1", rsp_valid, 2'b10);
        cyc();
        smp();
        chk("ws_rsp0", rsp_valid, 2'b01);

        // Error with a pipelined transfer behind it.
        idle(4);
        set_req(0, 1, 1, 0, 32'h500, 32'h1234_5678);
        smp();
        chk("err_gnt0", req_gnt, 2'b01);
        push(0, 32'h0, 1'b1);
        cyc();
        req[0] = 1'b0;
        set_req(1, 1, 0, 0, 32'h600, 0);
        smp();
        chk("err_gnt1", req_gnt, 2'b10);
        push(1, 32'h0, 1'b1);
        cyc();
        req[1] = 1'b0;
        hresp  = 1'b1;
        hready = 1'b0;
        smp();
        chk("err1_htrans", htrans, 0);
        chk("err1_hsel", hsel, 1);
        cyc();
        hready = 1'b1;
        smp();
        chk("err2_htrans", htrans, 0);
        cyc();
        hresp   = 1'b0;
        err_clr = 1'b1;
        smp();
        chk("err_rsp0", rsp_valid, 2'b01);
        chk("err_flag", error, 1);
        cyc();
        smp();
        chk("err_rsp1", rsp_valid, 2'b10);
        chk("err_set_wins", error, 1);
        cyc();
        err_clr = 1'b0;
        smp();
        chk("err_cleared", error, 0);

        // Lock: requester 0 holds the bus for three transfers.
        idle(4);
        set_req(0, 1, 0, 1, 32'h700, 0);
        set_req(1, 1, 0, 0, 32'h800, 0);
        for (int k = 0; k < 3; k++) begin
            smp();
            chk("lock_gnt", req_gnt, 2'b01);
            push(0, (32'h700 + 32'(4*k)) ^ 32'hC0DE_0000, 1'b0);
            if (k > 0) chk("lock_hmastlock", hmastlock, 1);
            cyc();
            if (k < 2) begin
                set_req(0, 1, 0, 1, 32'h700 + 32'(4*(k+1)), 0);
            end else begin
                req[0]      = 1'b0;
                req_lock[0] = 1'b0;
            end
        end
        smp();
        chk("lock_release_gnt", req_gnt, 2'b10);
        chk("lock_hmastlock_last", hmastlock, 1);
        push(1, 32'hC0DE_0800, 1'b0);
        cyc();
        req[1] = 1'b0;
        smp();
        chk("lock_hmastlock_off", hmastlock, 0);
        chk("lock_haddr1", haddr, 32'h800);

        // Reset while a read sits in the data phase.
        idle(4);
        set_req(0, 1, 0, 0, 32'h900, 0);
        smp();
        chk("rst_mid_gnt", req_gnt, 2'b01);
        cyc();
        req[0] = 1'b0;
        smp();
        chk("rst_mid_htrans", htrans, 2);
        cyc();
        hready = 1'b0;
        #2;
        hresetn = 1'b0;
        smp();
        chk("rst_mid_htrans_idle", htrans, 0);
        chk("rst_mid_hsel", hsel, 0);
        chk("rst_mid_haddr", haddr, 0);
        cyc();
        smp();
        chk("rst_mid_no_rsp0", rsp_valid, 0);
        cyc();
        hready = 1'b1;
        smp();
        chk("rst_mid_no_rsp1", rsp_valid, 0);
        cyc();
        hresetn = 1'b1;
        smp();
        chk("rst_mid_no_rsp2", rsp_valid, 0);
        cyc();
        set_req(1, 1, 0, 0, 32'hA00, 0);
        smp();
        chk("post_rst_gnt", req_gnt, 2'b10);
        push(1, 32'hC0DE_0A00, 1'b0);
        cyc();
        req[1] = 1'b0;
        smp();
        chk("post_rst_htrans", htrans, 2);
        chk("post_rst_haddr", haddr, 32'hA00);

        for (int i = 0; i < 20 && sb.size() > 0; i++) cyc();
        idle(2);
        chk("sb_drain", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
